mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Two-master arbiter upstream of the memory peripherals. Master 0 is instruction fetch; master 1 is data. It drives one shared request bus and routes each registered response back to its issuer.

Interface
REQ-001 SHALL have parameter FIXED_PRIORITY, default 0, meaning: 0 = round-robin arbitration, 1 = master 1 wins ties.
REQ-002 SHALL have parameter MAX_WAIT, default 4, meaning: consecutive stalled cycles after which a master is force-granted (used only when FIXED_PRIORITY=1); legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have, for N in {0,1}, these inputs: i_mN_req_addr (ADDR_W), i_mN_req_wr_data (WORD_W), i_mN_req_wr_en (1), i_mN_req_count (MEM_COUNT_W): request from master N.
REQ-006 SHALL have, for N in {0,1}, output o_mN_stall, 1 bit: request not granted this cycle; master N holds its request unchanged.
REQ-007 SHALL have, for N in {0,1}, these outputs: o_mN_res_valid (1), o_mN_res_rd_data (WORD_W), o_mN_res_code (MEM_CODE_W): response to master N.
REQ-008 SHALL have these outputs to the downstream memory: o_req_addr (ADDR_W), o_req_wr_data (WORD_W), o_req_wr_en (1), o_req_count (MEM_COUNT_W).
REQ-009 SHALL have these inputs from the downstream memory: i_res_rd_data (WORD_W), i_res_code (MEM_CODE_W); the downstream registers its response one cycle after the request.

Function
REQ-010 SHALL treat master N as requesting when i_mN_req_count != MEM_COUNT_NONE.
REQ-011 SHALL compute the grant combinationally in the same cycle as the request.
- If exactly one master is requesting, that master is granted.
- If neither is requesting, nothing is granted.
REQ-012 SHALL, when both request and FIXED_PRIORITY=0, grant the master not recorded in r_last_grant; r_last_grant updates on every grant.
REQ-013 SHALL, when both request and FIXED_PRIORITY=1, grant master 1, unless master 0's wait counter equals MAX_WAIT, in which case master 0 is granted.
REQ-014 SHALL keep a 4-bit wait counter per master.
- Increments, saturating at 15, each cycle the master requests and is stalled.
- Clears on the cycle the master is granted or the master stops requesting.
REQ-015 SHALL forward the granted master's addr, wr_data, wr_en and count unmodified to the o_req_* outputs.
REQ-016 SHALL, when nothing is granted, drive o_req_count = MEM_COUNT_NONE and o_req_addr/o_req_wr_data/o_req_wr_en = 0.
REQ-017 SHALL assert o_mN_stall = 1 exactly when master N requests and is not granted; o_mN_stall = 0 otherwise.
REQ-018 SHALL register the owner of each issued request (r_pend_valid, r_pend_owner) at the clock edge that issues it.
REQ-019 SHALL, in the cycle after issue, drive o_mOWNER_res_valid=1, o_mOWNER_res_rd_data = i_res_rd_data and o_mOWNER_res_code = i_res_code; latency is exactly 1 cycle.
REQ-020 SHALL drive, for any master that does not own the current response: res_valid=0, res_rd_data=0, res_code=MEM_CODE_INVALID.
REQ-021 SHALL support back-to-back issue with no bubble: a new grant may coincide with the prior request's response cycle.
REQ-022 SHALL allow the two masters' requests to alternate every cycle under round-robin with both requesting continuously.
REQ-023 SHALL NOT inspect or alter response codes; misaligned/out-of-bounds codes pass through unchanged.

Reset
REQ-024 SHALL, while aresetn=0, hold the following:
- o_req_count = MEM_COUNT_NONE; o_req_addr, o_req_wr_data, o_req_wr_en = 0.
- o_m0_stall = o_m1_stall = 1.
- All res_valid = 0, res_rd_data = 0, res_code = MEM_CODE_INVALID.
REQ-025 SHALL reset r_last_grant = 1 (master 0 wins the first tie), r_pend_valid = 0, r_pend_owner = 0, and both wait counters = 0.
REQ-026 SHALL discard a pending response when reset asserts mid-transaction; no res_valid follows reset release.

Verification
REQ-027 Single master: m1 read, word, addr 0x8, memory returns 0xDEADBEEF/MEM_CODE_READ -> o_m1_stall=0; next cycle o_m1_res_valid=1, data 0xDEADBEEF; o_m0_res_valid=0.
REQ-028 Round-robin tie: both request continuously for 4 cycles after reset -> grants m0,m1,m0,m1; each response goes to the matching master one cycle later.
REQ-029 Fixed-priority starvation (FIXED_PRIORITY=1, MAX_WAIT=4): both request continuously -> m1 granted 4 cycles, m0 granted on cycle 5, then m1 resumes.
REQ-030 Write passthrough: m0 byte write, addr 0x3, data 0xA5 -> o_req_* equal m0 inputs that cycle; next cycle o_m0_res_code = MEM_CODE_WRITE.
REQ-031 Error passthrough: m1 half read at addr 0x1 -> downstream MEM_CODE_MISALIGNED appears on o_m1_res_code with res_valid=1.
REQ-032 Reset mid-operation: assert aresetn=0 on the cycle after a grant -> no res_valid at any output; first tie after release goes to m0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-master (fetch / data) arbiter onto one shared memory
//               request bus, with one-cycle response routing to the issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int                     FIXED_PRIORITY   = 0,
    parameter int                     MAX_WAIT         = 4,
    parameter int                     ADDR_W           = 32,
    parameter int                     WORD_W           = 32,
    parameter int                     MEM_COUNT_W      = 2,
    parameter int                     MEM_CODE_W       = 3,
    parameter logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE   = '0,
    parameter logic [MEM_CODE_W-1:0]  MEM_CODE_INVALID = '0
) (
    input  logic                   clk,
    input  logic                   aresetn,

    input  logic [ADDR_W-1:0]      i_m0_req_addr,
    input  logic [WORD_W-1:0]      i_m0_req_wr_data,
    input  logic                   i_m0_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_m0_req_count,
    output logic                   o_m0_stall,
    output logic                   o_m0_res_valid,
    output logic [WORD_W-1:0]      o_m0_res_rd_data,
    output logic [MEM_CODE_W-1:0]  o_m0_res_code,

    input  logic [ADDR_W-1:0]      i_m1_req_addr,
    input  logic [WORD_W-1:0]      i_m1_req_wr_data,
    input  logic                   i_m1_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_m1_req_count,
    output logic                   o_m1_stall,
    output logic                   o_m1_res_valid,
    output logic [WORD_W-1:0]      o_m1_res_rd_data,
    output logic [MEM_CODE_W-1:0]  o_m1_res_code,

    output logic [ADDR_W-1:0]      o_req_addr,
    output logic [WORD_W-1:0]      o_req_wr_data,
    output logic                   o_req_wr_en,
    output logic [MEM_COUNT_W-1:0] o_req_count,

    input  logic [WORD_W-1:0]      i_res_rd_data,
    input  logic [MEM_CODE_W-1:0]  i_res_code
);

    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);
    localparam logic [3:0] c_wait_sat = 4'hF;
    localparam bit         c_fixed    = (FIXED_PRIORITY != 0);

    logic       w_m0_active;
    logic       w_m1_active;
    logic       w_grant_valid;
    logic       w_grant_owner;

    logic       r_last_grant_q, r_last_grant_d;
    logic       r_pend_valid_q, r_pend_valid_d;
    logic       r_pend_owner_q, r_pend_owner_d;
    logic [3:0] r_m0_wait_q,    r_m0_wait_d;
    logic [3:0] r_m1_wait_q,    r_m1_wait_d;

    // Requests are masked while reset is held so the bus stays idle and both
    // masters see a stall.
    always_comb begin
        w_m0_active   = aresetn && (i_m0_req_count != MEM_COUNT_NONE);
        w_m1_active   = aresetn && (i_m1_req_count != MEM_COUNT_NONE);
        w_grant_valid = w_m0_active || w_m1_active;
        w_grant_owner = 1'b0;
        if (w_m0_active && w_m1_active) begin
            if (c_fixed) begin
                w_grant_owner = (r_m0_wait_q != c_max_wait);
            end else begin
                w_grant_owner = ~r_last_grant_q;
            end
        end else begin
            w_grant_owner = w_m1_active;
        end
    end

    always_comb begin
        o_req_addr    = '0;
        o_req_wr_data = '0;
        o_req_wr_en   = 1'b0;
        o_req_count   = MEM_COUNT_NONE;
        if (w_grant_valid) begin
            if (w_grant_owner) begin
                o_req_addr    = i_m1_req_addr;
                o_req_wr_data = i_m1_req_wr_data;
                o_req_wr_en   = i_m1_req_wr_en;
                o_req_count   = i_m1_req_count;
            end else begin
                o_req_addr    = i_m0_req_addr;
                o_req_wr_data = i_m0_req_wr_data;
                o_req_wr_en   = i_m0_req_wr_en;
                o_req_count   = i_m0_req_count;
            end
        end
    end

    always_comb begin
        o_m0_stall = ~aresetn | (w_m0_active &  w_grant_owner);
        o_m1_stall = ~aresetn | (w_m1_active & ~w_grant_owner);
    end

    always_comb begin
        r_last_grant_d = w_grant_valid ? w_grant_owner : r_last_grant_q;
        r_pend_valid_d = w_grant_valid;
        r_pend_owner_d = w_grant_valid ? w_grant_owner : r_pend_owner_q;

        r_m0_wait_d = 4'd0;
        if (w_m0_active && w_grant_owner) begin
            r_m0_wait_d = (r_m0_wait_q == c_wait_sat) ? c_wait_sat : r_m0_wait_q + 4'd1;
        end

        r_m1_wait_d = 4'd0;
        if (w_m1_active && !w_grant_owner) begin
            r_m1_wait_d = (r_m1_wait_q == c_wait_sat) ? c_wait_sat : r_m1_wait_q + 4'd1;
        end
    end

    // Last-grant resets to master 1 so the first tie goes to master 0.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_last_grant_q <= 1'b1;
            r_pend_valid_q <= 1'b0;
            r_pend_owner_q <= 1'b0;
            r_m0_wait_q    <= 4'd0;
            r_m1_wait_q    <= 4'd0;
        end else begin
            r_last_grant_q <= r_last_grant_d;
            r_pend_valid_q <= r_pend_valid_d;
            r_pend_owner_q <= r_pend_owner_d;
            r_m0_wait_q    <= r_m0_wait_d;
            r_m1_wait_q    <= r_m1_wait_d;
        end
    end

    // Response codes pass through untouched; only ownership is decided here.
    always_comb begin
        o_m0_res_valid   = r_pend_valid_q & ~r_pend_owner_q;
        o_m1_res_valid   = r_pend_valid_q &  r_pend_owner_q;
        o_m0_res_rd_data = o_m0_res_valid ? i_res_rd_data : '0;
        o_m1_res_rd_data = o_m1_res_valid ? i_res_rd_data : '0;
        o_m0_res_code    = o_m0_res_valid ? i_res_code : MEM_CODE_INVALID;
        o_m1_res_code    = o_m1_res_valid ? i_res_code : MEM_CODE_INVALID;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter, round-robin and
//               fixed-priority instances driven by the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 2;
    localparam int KW = 3;
    localparam int MAXW = 4;

    localparam logic [CW-1:0] C_NONE = 2'd0;
    localparam logic [CW-1:0] C_BYTE = 2'd1;
    localparam logic [CW-1:0] C_HALF = 2'd2;
    localparam logic [CW-1:0] C_WORD = 2'd3;

    localparam logic [KW-1:0] K_INVALID    = 3'd0;
    localparam logic [KW-1:0] K_READ       = 3'd1;
    localparam logic [KW-1:0] K_WRITE      = 3'd2;
    localparam logic [KW-1:0] K_MISALIGNED = 3'd3;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_wen, m1_wen;
    logic [CW-1:0] m0_cnt, m1_cnt;
    logic [DW-1:0] res_rd_data;
    logic [KW-1:0] res_code;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic [1:0]    s0, s1, rv0, rv1, req_wen;
    logic [DW-1:0] rd0 [2];
    logic [DW-1:0] rd1 [2];
    logic [KW-1:0] code0 [2];
    logic [KW-1:0] code1 [2];
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_wdata [2];
    logic [CW-1:0] req_cnt [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gk = 0; gk < 2; gk++) begin : g_dut
        mem_arbiter #(
            .FIXED_PRIORITY (gk),
            .MAX_WAIT       (MAXW),
            .ADDR_W         (AW),
            .WORD_W         (DW),
            .MEM_COUNT_W    (CW),
            .MEM_CODE_W     (KW),
            .MEM_COUNT_NONE (C_NONE),
            .MEM_CODE_INVALID(K_INVALID)
        ) u_dut (
            .clk              (clk),
            .aresetn          (aresetn),
            .i_m0_req_addr    (m0_addr),
            .i_m0_req_wr_data (m0_wdata),
            .i_m0_req_wr_en   (m0_wen),
            .i_m0_req_count   (m0_cnt),
            .o_m0_stall       (s0[gk]),
            .o_m0_res_valid   (rv0[gk]),
            .o_m0_res_rd_data (rd0[gk]),
            .o_m0_res_code    (code0[gk]),
            .i_m1_req_addr    (m1_addr),
            .i_m1_req_wr_data (m1_wdata),
            .i_m1_req_wr_en   (m1_wen),
            .i_m1_req_count   (m1_cnt),
            .o_m1_stall       (s1[gk]),
            .o_m1_res_valid   (rv1[gk]),
            .o_m1_res_rd_data (rd1[gk]),
            .o_m1_res_code    (code1[gk]),
            .o_req_addr       (req_addr[gk]),
            .o_req_wr_data    (req_wdata[gk]),
            .o_req_wr_en      (req_wen[gk]),
            .o_req_count      (req_cnt[gk]),
            .i_res_rd_data    (res_rd_data),
            .i_res_code       (res_code)
        );
    end

    // ---------------- reference model ----------------
    int last_g [2];
    int wait0  [2];
    int wait1  [2];
    bit pend_v [2];
    int pend_o [2];

    // -1 = no grant, otherwise index of granted master
    function automatic int model_grant(int k);
        bit a0 = (m0_cnt != C_NONE);
        bit a1 = (m1_cnt != C_NONE);
        if (a0 && a1) begin
            if (k == 0) return (last_g[k] == 1) ? 0 : 1;
            return (wait0[k] == MAXW) ? 0 : 1;
        end
        if (a0) return 0;
        if (a1) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < 2; k++) begin
                last_g[k] = 1; wait0[k] = 0; wait1[k] = 0;
                pend_v[k] = 0; pend_o[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int g;
                g = model_grant(k);
                wait0[k] = (m0_cnt != C_NONE && g != 0) ? ((wait0[k] < 15) ? wait0[k] + 1 : 15) : 0;
                wait1[k] = (m1_cnt != C_NONE && g != 1) ? ((wait1[k] < 15) ? wait1[k] + 1 : 15) : 0;
                pend_v[k] = (g >= 0);
                if (g >= 0) begin
                    pend_o[k] = g;
                    last_g[k] = g;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_m0(input logic [CW-1:0] c, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic w);
        m0_cnt = c; m0_addr = a; m0_wdata = d; m0_wen = w;
    endtask

    task automatic set_m1(input logic [CW-1:0] c, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic w);
        m1_cnt = c; m1_addr = a; m1_wdata = d; m1_wen = w;
    endtask

    task automatic idle();
        set_m0(C_NONE, '0, '0, 1'b0);
        set_m1(C_NONE, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        aresetn = 1'b0;
        idle();
        @(posedge clk); #1;
        aresetn = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(posedge clk); #1;
        aresetn = 1'b0;
        set_m0(C_WORD, 32'h10, 32'h1, 1'b1);
        set_m1(C_WORD, 32'h20, 32'h2, 1'b0);
        res_rd_data = 32'hCAFE_F00D; res_code = K_READ;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (req_cnt[k] !== C_NONE || req_addr[k] !== '0 || req_wdata[k] !== '0 || req_wen[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_req[%0d]: got cnt=%h addr=%h wd=%h wen=%b, want cnt=0 addr=0 wd=0 wen=0",
                         k, req_cnt[k], req_addr[k], req_wdata[k], req_wen[k]);
            end
            checks++;
            if (s0[k] !== 1'b1 || s1[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_stall[%0d]: got s0=%b s1=%b, want 1 1", k, s0[k], s1[k]);
            end
            checks++;
            if (rv0[k] !== 1'b0 || rv1[k] !== 1'b0 || rd0[k] !== '0 || rd1[k] !== '0 ||
                code0[k] !== K_INVALID || code1[k] !== K_INVALID) begin
                errors++;
                $display("FAIL reset_res[%0d]: got v=%b%b d=%h/%h c=%h/%h, want v=00 d=0 c=invalid",
                         k, rv0[k], rv1[k], rd0[k], rd1[k], code0[k], code1[k]);
            end
        end
        @(posedge clk); #1;
        aresetn = 1'b1;
        idle();
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        set_m1(C_WORD, 32'h8, '0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (s1[k] !== 1'b0 || req_addr[k] !== 32'h8 || req_cnt[k] !== C_WORD) begin
                errors++;
                $display("FAIL single_issue[%0d]: got s1=%b addr=%h cnt=%h, want 0 8 %h",
                         k, s1[k], req_addr[k], req_cnt[k], C_WORD);
            end
        end
        @(posedge clk); #1;
        idle();
        res_rd_data = 32'hDEAD_BEEF; res_code = K_READ;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rv1[k] !== 1'b1 || rd1[k] !== 32'hDEAD_BEEF || code1[k] !== K_READ) begin
                errors++;
                $display("FAIL single_resp[%0d]: got v=%b d=%h c=%h, want 1 deadbeef %h",
                         k, rv1[k], rd1[k], code1[k], K_READ);
            end
            checks++;
            if (rv0[k] !== 1'b0 || rd0[k] !== '0 || code0[k] !== K_INVALID) begin
                errors++;
                $display("FAIL single_other[%0d]: got v=%b d=%h c=%h, want 0 0 invalid",
                         k, rv0[k], rd0[k], code0[k]);
            end
        end
    endtask

    task automatic test_tie_sequence();
        int exp_g [2][7] = '{'{0, 1, 0, 1, 0, 1, 0}, '{1, 1, 1, 1, 0, 1, 1}};
        int prev  [2] = '{-1, -1};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            set_m0(C_WORD, 32'h100, '0, 1'b0);
            set_m1(C_WORD, 32'h200, '0, 1'b0);
            res_rd_data = $urandom;
            res_code = K_READ;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (s0[k] !== (exp_g[k][c] != 0) || s1[k] !== (exp_g[k][c] == 0) ||
                    req_addr[k] !== ((exp_g[k][c] == 0) ? 32'h100 : 32'h200)) begin
                    errors++;
                    $display("FAIL tie_grant[%0d] cycle %0d: got s0=%b s1=%b addr=%h, want grant m%0d",
                             k, c, s0[k], s1[k], req_addr[k], exp_g[k][c]);
                end
                if (prev[k] >= 0) begin
                    checks++;
                    if (rv0[k] !== (prev[k] == 0) || rv1[k] !== (prev[k] == 1) ||
                        ((prev[k] == 0) ? rd0[k] : rd1[k]) !== res_rd_data) begin
                        errors++;
                        $display("FAIL tie_resp[%0d] cycle %0d: got v=%b%b, want owner m%0d data %h",
                                 k, c, rv0[k], rv1[k], prev[k], res_rd_data);
                    end
                end
                prev[k] = exp_g[k][c];
            end
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_write();
        @(posedge clk); #1;
        set_m0(C_BYTE, 32'h3, 32'hA5, 1'b1);
        set_m1(C_NONE, 32'h77, 32'h66, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (req_addr[k] !== 32'h3 || req_wdata[k] !== 32'hA5 || req_wen[k] !== 1'b1 ||
                req_cnt[k] !== C_BYTE || s0[k] !== 1'b0) begin
                errors++;
                $display("FAIL write_pass[%0d]: got addr=%h wd=%h wen=%b cnt=%h s0=%b, want 3 a5 1 %h 0",
                         k, req_addr[k], req_wdata[k], req_wen[k], req_cnt[k], s0[k], C_BYTE);
            end
        end
        @(posedge clk); #1;
        idle();
        res_rd_data = '0; res_code = K_WRITE;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rv0[k] !== 1'b1 || code0[k] !== K_WRITE || rv1[k] !== 1'b0) begin
                errors++;
                $display("FAIL write_resp[%0d]: got v0=%b c0=%h v1=%b, want 1 %h 0",
                         k, rv0[k], code0[k], rv1[k], K_WRITE);
            end
        end
    endtask

    task automatic test_error_pass();
        @(posedge clk); #1;
        set_m1(C_HALF, 32'h1, '0, 1'b0);
        @(posedge clk); #1;
        idle();
        res_rd_data = 32'h1234; res_code = K_MISALIGNED;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rv1[k] !== 1'b1 || code1[k] !== K_MISALIGNED || code0[k] !== K_INVALID) begin
                errors++;
                $display("FAIL error_pass[%0d]: got v1=%b c1=%h c0=%h, want 1 %h invalid",
                         k, rv1[k], code1[k], code0[k], K_MISALIGNED);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        set_m0(C_WORD, 32'h40, '0, 1'b0);
        @(posedge clk); #1;
        aresetn = 1'b0;
        idle();
        res_code = K_READ;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rv0[k] !== 1'b0 || rv1[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_mid_res[%0d] step %0d: got v=%b%b, want 00", k, c, rv0[k], rv1[k]);
                end
            end
            @(posedge clk); #1;
            aresetn = 1'b1;
        end
        set_m0(C_WORD, 32'h50, '0, 1'b0);
        set_m1(C_WORD, 32'h60, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (s0[0] !== 1'b0 || s1[0] !== 1'b1 || req_addr[0] !== 32'h50) begin
            errors++;
            $display("FAIL reset_mid_tie: got s0=%b s1=%b addr=%h, want 0 1 50", s0[0], s1[0], req_addr[0]);
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            set_m0(($urandom_range(0, 9) < 3) ? C_NONE : CW'($urandom_range(1, 3)),
                   $urandom, $urandom, 1'($urandom));
            set_m1(($urandom_range(0, 9) < 3) ? C_NONE : CW'($urandom_range(1, 3)),
                   $urandom, $urandom, 1'($urandom));
            res_rd_data = $urandom;
            res_code = KW'($urandom_range(0, 7));
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int g;
                logic [AW-1:0] e_addr;
                logic [DW-1:0] e_wd;
                logic          e_wen;
                logic [CW-1:0] e_cnt;
                logic          e_v0, e_v1;
                g = model_grant(k);
                e_addr = (g == 0) ? m0_addr  : (g == 1) ? m1_addr  : '0;
                e_wd   = (g == 0) ? m0_wdata : (g == 1) ? m1_wdata : '0;
                e_wen  = (g == 0) ? m0_wen   : (g == 1) ? m1_wen   : 1'b0;
                e_cnt  = (g == 0) ? m0_cnt   : (g == 1) ? m1_cnt   : C_NONE;
                e_v0   = pend_v[k] && pend_o[k] == 0;
                e_v1   = pend_v[k] && pend_o[k] == 1;
                checks++;
                if (req_addr[k] !== e_addr || req_wdata[k] !== e_wd || req_wen[k] !== e_wen || req_cnt[k] !== e_cnt) begin
                    errors++;
                    $display("FAIL rand_req[%0d] cycle %0d: got %h/%h/%b/%h, want %h/%h/%b/%h",
                             k, c, req_addr[k], req_wdata[k], req_wen[k], req_cnt[k], e_addr, e_wd, e_wen, e_cnt);
                end
                checks++;
                if (s0[k] !== (m0_cnt != C_NONE && g != 0) || s1[k] !== (m1_cnt != C_NONE && g != 1)) begin
                    errors++;
                    $display("FAIL rand_stall[%0d] cycle %0d: got s0=%b s1=%b, want grant %0d",
                             k, c, s0[k], s1[k], g);
                end
                checks++;
                if (rv0[k] !== e_v0 || rd0[k] !== (e_v0 ? res_rd_data : '0) ||
                    code0[k] !== (e_v0 ? res_code : K_INVALID)) begin
                    errors++;
                    $display("FAIL rand_res0[%0d] cycle %0d: got v=%b d=%h c=%h, want v=%b",
                             k, c, rv0[k], rd0[k], code0[k], e_v0);
                end
                checks++;
                if (rv1[k] !== e_v1 || rd1[k] !== (e_v1 ? res_rd_data : '0) ||
                    code1[k] !== (e_v1 ? res_code : K_INVALID)) begin
                    errors++;
                    $display("FAIL rand_res1[%0d] cycle %0d: got v=%b d=%h c=%h, want v=%b",
                             k, c, rv1[k], rd1[k], code1[k], e_v1);
                end
            end
        end
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        idle();
        res_rd_data = '0;
        res_code = K_INVALID;
        test_reset();
        test_single_read();
        test_tie_sequence();
        test_write();
        test_error_pass();
        test_reset_mid();
        test_random();
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
